// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA scan generator feeding a ping-pong line
// buffer. Produces syncs, a wrapping buffer read address, half-buffer refill
// requests, a frame interrupt and a completed-frame counter. Sync and blanking
// are delayed by RAM_LATENCY so they leave aligned with the pixel data.
// Optional build macro: VGA_TEST_PATTERN_EN adds a testMode input that
// replaces active pixels with eight vertical colour bars.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned HSYNC_POL   = 0,
  parameter int unsigned VSYNC_POL   = 0,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              clk25MHz,
  input  logic              reset,
  input  logic [15:0]       ramData,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              testMode,
`endif
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramClk,
  output logic [15:0]       vgaData,
  output logic              hsync,
  output logic              vsync,
  output logic              dataReq,
  output logic              reqHalf,
  output logic              frameIrq,
  output logic [FCNT_W-1:0] frameCount
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW      = $clog2(H_TOTAL);
  localparam int unsigned VCW      = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned H_MID    = H_TOTAL / 2;
  localparam logic        HS_ON    = (HSYNC_POL != 0);
  localparam logic        VS_ON    = (VSYNC_POL != 0);
  localparam logic [ADDR_W-1:0] ADDR_HALF = {1'b1, {(ADDR_W-1){1'b0}}};

  // Scan position
  logic [HCW-1:0]    h_cnt_q, h_cnt_d;
  logic [VCW-1:0]    v_cnt_q, v_cnt_d;
  logic [31:0]       h_pos, v_pos;
  logic              h_last, v_last, frame_wrap, active;
  logic              hs_raw, vs_raw;

  // Sync delay pipes; the last stage drives the pin
  logic [RAM_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
  logic [RAM_LATENCY-1:0] vs_pipe_q, vs_pipe_d;

  // Buffer address and refill requests
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, addr_inc;
  logic              step_half, step_wrap, pre_lo, pre_hi;
  logic              data_req_q, data_req_d;
  logic              req_half_q, req_half_d;

  // Frame events
  logic              frame_evt;
  logic              frame_irq_q, frame_irq_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;

  // Pixel path
  logic              act_tap;
  logic [15:0]       vga_data_q, vga_data_d;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  logic [31:0] bar_idx;
  logic [2:0]  bar_raw, bar_tap;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Colour bar index of the current column, clamped to the last bar
  always_comb begin
    bar_idx = h_pos / BAR_W;
    bar_raw = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
  end
`endif

  // Counter advance, region decode and raw (undelayed) sync levels
  always_comb begin
    h_pos      = 32'(h_cnt_q);
    v_pos      = 32'(v_cnt_q);
    h_last     = (h_pos == H_TOTAL - 1);
    v_last     = (v_pos == V_TOTAL - 1);
    frame_wrap = h_last && v_last;
    h_cnt_d    = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
    active = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    hs_raw = ((h_pos >= HS_START) && (h_pos < HS_END)) ? HS_ON : ~HS_ON;
    vs_raw = ((v_pos >= VS_START) && (v_pos < VS_END)) ? VS_ON : ~VS_ON;
  end

  // Sync shift registers: register plus RAM_LATENCY-1 further stages
  always_comb begin
    hs_pipe_d = RAM_LATENCY'({hs_pipe_q, hs_raw});
    vs_pipe_d = RAM_LATENCY'({vs_pipe_q, vs_raw});
  end

  // Address stepping and half-buffer refill request decode
  always_comb begin
    addr_inc   = ram_addr_q + 1'b1;
    ram_addr_d = ram_addr_q;
    if (frame_wrap) begin
      ram_addr_d = '0;
    end else if (active) begin
      ram_addr_d = addr_inc;
    end
    // The frame-start reset is not an increment, so it never raises a request
    step_half  = active && !frame_wrap && (addr_inc == ADDR_HALF);
    step_wrap  = active && !frame_wrap && (addr_inc == '0);
    pre_lo     = v_last && (h_pos == 32'd0);
    pre_hi     = v_last && (h_pos == H_MID);
    data_req_d = step_half || step_wrap || pre_lo || pre_hi;
    req_half_d = req_half_q;
    if (step_wrap || pre_hi) begin
      req_half_d = 1'b1;
    end else if (step_half || pre_lo) begin
      req_half_d = 1'b0;
    end
  end

  // Frame interrupt and completed-frame counter at the start of vertical blank
  always_comb begin
    frame_evt     = (h_pos == 32'd0) && (v_pos == V_ACTIVE);
    frame_irq_d   = frame_evt;
    frame_count_d = frame_evt ? frame_count_q + 1'b1 : frame_count_q;
  end

  // Active flag (and bar index) delayed RAM_LATENCY-1 cycles to meet ramData;
  // the output register supplies the final cycle of delay.
  generate
    if (RAM_LATENCY == 1) begin : g_tap_direct
      assign act_tap = active;
`ifdef VGA_TEST_PATTERN_EN
      assign bar_tap = bar_raw;
`endif
    end else begin : g_tap_pipe
      logic [RAM_LATENCY-2:0] act_pipe_q, act_pipe_d;
`ifdef VGA_TEST_PATTERN_EN
      logic [3*(RAM_LATENCY-1)-1:0] bar_pipe_q, bar_pipe_d;
`endif

      // Shift the active flag (and bar index) one stage per pixel clock
      always_comb begin
        act_pipe_d = (RAM_LATENCY-1)'({act_pipe_q, active});
`ifdef VGA_TEST_PATTERN_EN
        bar_pipe_d = (3*(RAM_LATENCY-1))'({bar_pipe_q, bar_raw});
`endif
      end

      // Delay-pipe registers, cleared on reset
      always_ff @(posedge clk25MHz) begin
        if (reset) begin
          act_pipe_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
          bar_pipe_q <= '0;
`endif
        end else begin
          act_pipe_q <= act_pipe_d;
`ifdef VGA_TEST_PATTERN_EN
          bar_pipe_q <= bar_pipe_d;
`endif
        end
      end

      assign act_tap = act_pipe_q[RAM_LATENCY-2];
`ifdef VGA_TEST_PATTERN_EN
      assign bar_tap = bar_pipe_q[3*(RAM_LATENCY-1)-1 -: 3];
`endif
    end
  endgenerate

  // Output pixel mux: blank outside the delayed active region
  always_comb begin
    vga_data_d = 16'h0000;
    if (act_tap) begin
`ifdef VGA_TEST_PATTERN_EN
      vga_data_d = testMode ? bar_color(bar_tap) : ramData;
`else
      vga_data_d = ramData;
`endif
    end
  end

  // State registers; reset wins over every other event on the same edge
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_pipe_q     <= {RAM_LATENCY{~HS_ON}};
      vs_pipe_q     <= {RAM_LATENCY{~VS_ON}};
      ram_addr_q    <= '0;
      data_req_q    <= 1'b0;
      req_half_q    <= 1'b0;
      frame_irq_q   <= 1'b0;
      frame_count_q <= '0;
      vga_data_q    <= 16'h0000;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      ram_addr_q    <= ram_addr_d;
      data_req_q    <= data_req_d;
      req_half_q    <= req_half_d;
      frame_irq_q   <= frame_irq_d;
      frame_count_q <= frame_count_d;
      vga_data_q    <= vga_data_d;
    end
  end

  assign ramClk     = clk25MHz;
  assign ramAddr    = ram_addr_q;
  assign hsync      = hs_pipe_q[RAM_LATENCY-1];
  assign vsync      = vs_pipe_q[RAM_LATENCY-1];
  assign dataReq    = data_req_q;
  assign reqHalf    = req_half_q;
  assign frameIrq   = frame_irq_q;
  assign frameCount = frame_count_q;
  assign vgaData    = vga_data_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances on one clock. Instance A uses the
// default horizontal timing with a short vertical frame; instance B is a tiny
// configuration with RAM_LATENCY=3, positive hsync and a 2-bit frame counter.
// A frame-position model predicts every output on every cycle; hand-computed
// literals pin specific cycles.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, aw, lat, fw;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [15:0] addr;
    logic        req;
    logic        half;
    logic        irq;
    logic [15:0] fcnt;
    logic [15:0] vga;
  } obs_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] ram_data_a, ram_data_b;
  logic [9:0]  ram_addr_a;
  logic [2:0]  ram_addr_b;
  logic        ram_clk_a, ram_clk_b;
  logic [15:0] vga_a, vga_b;
  logic        hsync_a, hsync_b, vsync_a, vsync_b;
  logic        req_a, req_b, half_a_o, half_b_o, irq_a, irq_b;
  logic [15:0] fcnt_a;
  logic [1:0]  fcnt_b;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(0), .VSYNC_POL(0), .ADDR_W(10), .RAM_LATENCY(1), .FCNT_W(16)
  ) u_a (
    .clk25MHz(clk), .reset(rst_a), .ramData(ram_data_a),
`ifdef VGA_TEST_PATTERN_EN
    .testMode(1'b0),
`endif
    .ramAddr(ram_addr_a), .ramClk(ram_clk_a), .vgaData(vga_a),
    .hsync(hsync_a), .vsync(vsync_a), .dataReq(req_a), .reqHalf(half_a_o),
    .frameIrq(irq_a), .frameCount(fcnt_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(0), .ADDR_W(3), .RAM_LATENCY(3), .FCNT_W(2)
  ) u_b (
    .clk25MHz(clk), .reset(rst_b), .ramData(ram_data_b),
`ifdef VGA_TEST_PATTERN_EN
    .testMode(1'b0),
`endif
    .ramAddr(ram_addr_b), .ramClk(ram_clk_b), .vgaData(vga_b),
    .hsync(hsync_b), .vsync(vsync_b), .dataReq(req_b), .reqHalf(half_b_o),
    .frameIrq(irq_b), .frameCount(fcnt_b)
  );

  // Buffer RAM models: data returns the address it was read from. The DUT's
  // output register is the final cycle, so the RAM contributes latency-1.
  assign ram_data_a = 16'(ram_addr_a);
  logic [2:0] hist_b [2];
  always @(posedge clk) begin
    hist_b[0] <= ram_addr_b;
    hist_b[1] <= hist_b[0];
  end
  assign ram_data_b = 16'(hist_b[1]);

  cfg_t ca = '{640, 16, 96, 48, 20, 2, 2, 3, 0, 0, 10, 1, 16};
  cfg_t cb = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 3, 3, 2};

  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
      if (miss_cnt >= 40) begin
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
      end
    end
  endtask

  // Pixels already fetched in the current frame before scan cycle m
  function automatic int kpix(cfg_t c, int m);
    int ht, vt, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    h  = m % ht;
    v  = (m / ht) % vt;
    if (v < c.va) return v * c.ha + ((h < c.ha) ? h : c.ha);
    return c.va * c.ha;
  endfunction

  function automatic bit actv(cfg_t c, int m);
    int ht, vt, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    h  = m % ht;
    v  = (m / ht) % vt;
    return (h < c.ha) && (v < c.va);
  endfunction

  // Expected outputs n cycles after the last reset edge
  function automatic obs_t model(cfg_t c, int n, logic half_prev);
    obs_t e;
    int ht, vt, ft, amod, m, h, v, nx;
    ht   = c.ha + c.hf + c.hs + c.hb;
    vt   = c.va + c.vf + c.vs + c.vb;
    ft   = ht * vt;
    amod = 1 << c.aw;
    e    = '0;
    e.hs = (c.hpol != 0) ? 1'b0 : 1'b1;
    e.vs = (c.vpol != 0) ? 1'b0 : 1'b1;
    if (n >= c.lat) begin
      m = n - c.lat;
      h = m % ht;
      v = (m / ht) % vt;
      if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) e.hs = (c.hpol != 0);
      if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) e.vs = (c.vpol != 0);
      if (actv(c, m)) e.vga = 16'(kpix(c, m) % amod);
    end
    e.addr = 16'(kpix(c, n) % amod);
    e.half = half_prev;
    if (n >= 1) begin
      m = n - 1;
      h = m % ht;
      v = (m / ht) % vt;
      if (v == vt - 1 && h == 0) begin
        e.req = 1'b1; e.half = 1'b0;
      end else if (v == vt - 1 && h == ht / 2) begin
        e.req = 1'b1; e.half = 1'b1;
      end else if (actv(c, m)) begin
        nx = (kpix(c, m) + 1) % amod;
        if (nx == amod / 2) begin
          e.req = 1'b1; e.half = 1'b0;
        end else if (nx == 0) begin
          e.req = 1'b1; e.half = 1'b1;
        end
      end
      e.irq = (h == 0) && (v == c.va);
      if (m >= c.va * ht) e.fcnt = 16'(((m - c.va * ht) / ft + 1) % (1 << c.fw));
    end
    return e;
  endfunction

  // Cycles since the last reset edge (-1 before the first one)
  int n_a = -1;
  int n_b = -1;
  always @(posedge clk) begin
    if (rst_a) n_a <= 0; else if (n_a >= 0) n_a <= n_a + 1;
    if (rst_b) n_b <= 0; else if (n_b >= 0) n_b <= n_b + 1;
  end

  logic half_a = 1'b0;
  logic half_b = 1'b0;
  int   rq_a = 0;
  int   rq_b = 0;
  obs_t ea, eb, oa, ob;

  // Per-cycle compare against the model, plus literal spot checks
  always @(negedge clk) begin
    if (n_a >= 0) begin
      if (n_a == 0) begin
        half_a = 1'b0;
        rq_a   = 0;
      end
      ea = model(ca, n_a, half_a);
      half_a = ea.half;
      oa = '{hsync_a, vsync_a, 16'(ram_addr_a), req_a, half_a_o, irq_a, fcnt_a, vga_a};
      chk($sformatf("A_cycle n=%0d", n_a), 64'(oa), 64'(ea));
      if (req_a) rq_a++;
      case (n_a)
        0: begin
          chk("A_rst_syncs", 64'({hsync_a, vsync_a}), 64'd3);
          chk("A_rst_addr_vga", 64'({ram_addr_a, vga_a}), 64'd0);
        end
        100:   chk("A_ramclk", 64'(ram_clk_a), 64'(clk));
        512:   chk("A_req_first", 64'({req_a, half_a_o}), 64'b10);
        656:   chk("A_hsync_pre", 64'(hsync_a), 64'd1);
        657:   chk("A_hsync_fall", 64'(hsync_a), 64'd0);
        752:   chk("A_hsync_last", 64'(hsync_a), 64'd0);
        753:   chk("A_hsync_rise", 64'(hsync_a), 64'd1);
        1184:  chk("A_req_second", 64'({req_a, half_a_o}), 64'b11);
        16000: chk("A_irq_pre", 64'({irq_a, fcnt_a}), 64'h0_0000);
        16001: chk("A_irq_f1", 64'({irq_a, fcnt_a}), 64'h1_0001);
        17600: chk("A_vsync_pre", 64'(vsync_a), 64'd1);
        17601: chk("A_vsync_fall", 64'(vsync_a), 64'd0);
        19200: chk("A_vsync_last", 64'(vsync_a), 64'd0);
        19201: chk("A_vsync_rise", 64'(vsync_a), 64'd1);
        20801: chk("A_prefetch_lo", 64'({req_a, half_a_o}), 64'b10);
        21201: chk("A_prefetch_hi", 64'({req_a, half_a_o}), 64'b11);
        21600: chk("A_req_count", 64'(rq_a), 64'd27);
        37601: chk("A_irq_f2", 64'({irq_a, fcnt_a}), 64'h1_0002);
        default: ;
      endcase
    end
    if (n_b >= 0) begin
      if (n_b == 0) begin
        half_b = 1'b0;
        rq_b   = 0;
      end
      eb = model(cb, n_b, half_b);
      half_b = eb.half;
      ob = '{hsync_b, vsync_b, 16'(ram_addr_b), req_b, half_b_o, irq_b, 16'(fcnt_b), vga_b};
      chk($sformatf("B_cycle n=%0d", n_b), 64'(ob), 64'(eb));
      if (req_b) rq_b++;
      case (n_b)
        3:   chk("B_vga_px0", 64'(vga_b), 64'd0);
        4:   chk("B_req_px3", 64'({req_b, half_b_o, vga_b}), 64'h2_0001);
        7:   chk("B_addr_px7", 64'(ram_addr_b), 64'd7);
        8:   chk("B_req_px7", 64'({req_b, half_b_o}), 64'b11);
        10:  chk("B_vga_px7", 64'(vga_b), 64'd7);
        11:  chk("B_vga_blank", 64'(vga_b), 64'd0);
        12:  chk("B_hsync_pre", 64'(hsync_b), 64'd0);
        13:  chk("B_hsync_on1", 64'(hsync_b), 64'd1);
        14:  chk("B_hsync_on2", 64'(hsync_b), 64'd1);
        15:  chk("B_hsync_off", 64'(hsync_b), 64'd0);
        18:  chk("B_req_px11", 64'({req_b, half_b_o}), 64'b10);
        57:  chk("B_irq_f1", 64'({irq_b, fcnt_b}), 64'b101);
        98:  chk("B_req_count", 64'(rq_b), 64'd10);
        155: chk("B_irq_f2", 64'({irq_b, fcnt_b}), 64'b110);
        253: chk("B_irq_f3", 64'({irq_b, fcnt_b}), 64'b111);
        351: chk("B_irq_f4_wrap", 64'({irq_b, fcnt_b}), 64'b100);
        default: ;
      endcase
    end
  end

  // Stimulus: power-up reset, two full A frames, a one-cycle reset at
  // hCnt=300/vCnt=10 of the third frame, then a short run to see it re-time.
  initial begin
    int guard;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    guard = 0;
    while (n_a != 2 * 21600 + 10 * 800 + 300 && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    chk("A_reach_midframe", 64'(n_a), 64'(2 * 21600 + 10 * 800 + 300));
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;

    guard = 0;
    while (n_a != 2000 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("A_reach_after_reset", 64'(n_a), 64'd2000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
